reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-back stage and architectural register file of the sequential Y86-64 core; sits directly downstream of execute/memory.
- Holds the 15 program registers (index 14 = %rsp) and drives regmem0..regmem14 into decode.
- Selects dstE/dstM from icode/rA/rB/cnd and commits valE/valM on the clock edge.
- Tracks processor status through a small RUN/HALT/ERR state machine.

Parameters:
- SP_IDX, 14, register index used as stack pointer.
- SP_RESET, 64'h0000_0000_0000_0200, %rsp value after reset.
- NREG, 15, number of architectural registers (index 4'hF = "no register").

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  one instruction's results present this cycle.
- icode  in  4  instruction code of the retiring instruction.
- rA, rB  in  4 each  register specifiers from fetch.
- cnd  in  1  condition flag from execute (used by cmovXX).
- valE  in  64  ALU result.
- valM  in  64  memory read data.
- dmem_err  in  1  memory stage address error for this instruction.
- regmem0 .. regmem14  out  64 each  current register contents.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- wb_ready  out  1  high only in RUN; upstream must not advance when low.

Behaviour:
- Reset (async, any time, including mid-write): all registers 0 except reg[SP_IDX]=SP_RESET; state=RUN; stat=1; wb_ready=1. Any write in the reset cycle is discarded.
- dstE:
  - icode 2 (cmovXX): rB if cnd=1, else 4'hF.
  - icode 3 (irmovq) or 6 (OPq): rB.
  - icode 8/9/10/11 (call/ret/pushq/popq): SP_IDX.
  - Otherwise 4'hF.
- dstM: icode 5 (mrmovq) or 11 (popq): rA; otherwise 4'hF.
- Write rules, evaluated at the rising edge:
  - Writes occur only when wb_valid=1, state=RUN and dmem_err=0.
  - reg[dstE]<=valE if dstE!=4'hF; reg[dstM]<=valM if dstM!=4'hF.
  - Specifier 4'hF or any index >=NREG means no write.
  - Collision dstE==dstM (e.g. popq %rsp): valM wins.
- Latency: a write is visible on regmem* the cycle after the edge. There is no internal bypass; decode reads the registered values.
- State machine, evaluated only when wb_valid=1 in RUN, first matching rule wins:
  - dmem_err=1 -> ERR, stat=3, no register writes.
  - icode >11 -> ERR, stat=4, no register writes.
  - icode 0 (halt) -> HALT, stat=2.
  - Otherwise stay in RUN, stat=1.
- HALT and ERR are terminal until rst. wb_valid is ignored there, registers are frozen and wb_ready=0.
- The wb_valid=0 cycle is a bubble: no state or register change.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retired_cnt (64 bit), reset to 0.
  - Increments by 1 on every edge with wb_valid=1 in RUN, including the halt instruction itself.
  - Does not increment on ERR-causing instructions or bubbles.
  - Wraps from all-ones to 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT=0 … IPOPQ=11).
  - stat codes (SAOK, SHLT, SADR, SINS).
  - RNONE=4'hF.
  - Typedef word_t (64-bit).
  - State enum wb_state_t {RUN, HALT, ERR}.
- One natural sub-module: wb_dst_sel, combinational mapping of icode/rA/rB/cnd to dstE/dstM. It is reusable by the pipelined core.

Test Plan:
- Reset check: assert rst mid-cycle -> all regmem*=0, regmem14=64'h200, stat=1, wb_ready=1.
- Writes: irmovq (icode 3, rB=2, valE=64'h1234) -> regmem2=64'h1234 next cycle. Then cmovXX (icode 2, rB=3, cnd=0) -> regmem3 unchanged. With cnd=1, valE=5 -> regmem3=5.
- Collision: popq %rsp (icode 11, rA=14, valE=64'h208, valM=64'hABCD) -> regmem14=64'hABCD. Then popq rA=1, valE=64'h210, valM=7 -> regmem1=7 and regmem14=64'h210.
- Halt: icode 0 -> stat=2, wb_ready=0. A following irmovq rB=5 valE=9 -> regmem5 unchanged.
- Errors: mrmovq with dmem_err=1 -> stat=3, destination register unchanged. Separately, after reset, icode 12 -> stat=4. Asserting rst afterwards -> stat=1.
- With WB_RETIRE_CNT_EN: 3 valid instructions, 2 bubbles, then halt -> retired_cnt=4, and it stays 4 afterwards.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register indices and write-back state.
// Register-file geometry (NREG, SP_IDX, SP_RESET) lives here so decode and write-back agree.
package y86_pkg;

   typedef logic [63:0] word_t;

   localparam logic [3:0] IHALT   = 4'd0;
   localparam logic [3:0] INOP    = 4'd1;
   localparam logic [3:0] ICMOVXX = 4'd2;
   localparam logic [3:0] IIRMOVQ = 4'd3;
   localparam logic [3:0] IRMMOVQ = 4'd4;
   localparam logic [3:0] IMRMOVQ = 4'd5;
   localparam logic [3:0] IOPQ    = 4'd6;
   localparam logic [3:0] IJXX    = 4'd7;
   localparam logic [3:0] ICALL   = 4'd8;
   localparam logic [3:0] IRET    = 4'd9;
   localparam logic [3:0] IPUSHQ  = 4'd10;
   localparam logic [3:0] IPOPQ   = 4'd11;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] RNONE    = 4'hF;
   localparam logic [3:0] SP_IDX   = 4'd14;
   localparam word_t      SP_RESET = 64'h0000_0000_0000_0200;
   localparam int         NREG     = 15;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      ERR  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_dst_sel.sv
// Destination-register selection for write-back: maps icode/rA/rB/cnd to dstE and dstM.
// Purely combinational (zero latency), no handshake; shared with the pipelined core.
module wb_dst_sel
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   input  logic [3:0] ra,
   input  logic [3:0] rb,
   input  logic       cnd,
   output logic [3:0] dst_e,
   output logic [3:0] dst_m
);

   always_comb begin
      dst_e = RNONE;
      dst_m = RNONE;
      case (icode)
         ICMOVXX:                      dst_e = cnd ? rb : RNONE;
         IIRMOVQ, IOPQ:                dst_e = rb;
         ICALL, IRET, IPUSHQ, IPOPQ:   dst_e = SP_IDX;
         default:                      dst_e = RNONE;
      endcase
      if (icode == IMRMOVQ || icode == IPOPQ)
         dst_m = ra;
   end

endmodule

// File: rtl/reg_writeback.sv
// Y86-64 write-back stage + register file; writes visible on regmem* one cycle after the edge.
// wb_ready drops permanently on halt/error until rst. Optional retire counter: WB_RETIRE_CNT_EN.
module reg_writeback
   import y86_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wb_valid,
   input  logic [3:0] icode,
   input  logic [3:0] rA,
   input  logic [3:0] rB,
   input  logic       cnd,
   input  word_t      valE,
   input  word_t      valM,
   input  logic       dmem_err,
   output word_t      regmem0,
   output word_t      regmem1,
   output word_t      regmem2,
   output word_t      regmem3,
   output word_t      regmem4,
   output word_t      regmem5,
   output word_t      regmem6,
   output word_t      regmem7,
   output word_t      regmem8,
   output word_t      regmem9,
   output word_t      regmem10,
   output word_t      regmem11,
   output word_t      regmem12,
   output word_t      regmem13,
   output word_t      regmem14,
   output logic [2:0] stat,
`ifdef WB_RETIRE_CNT_EN
   output word_t      retired_cnt,
`endif
   output logic       wb_ready
);

   wb_state_t  state_q, next_state;
   logic [2:0] stat_q, next_stat;
   logic       commit;
   logic [3:0] dst_e, dst_m;
   word_t      rf [NREG];

   wb_dst_sel u_dst_sel (
      .icode (icode),
      .ra    (rA),
      .rb    (rB),
      .cnd   (cnd),
      .dst_e (dst_e),
      .dst_m (dst_m)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         stat_q  <= SAOK;
      end else begin
         state_q <= next_state;
         stat_q  <= next_stat;
      end
   end

   // Faulting instructions change status but never commit register results.
   always_comb begin
      next_state = state_q;
      next_stat  = stat_q;
      commit     = 1'b0;
      if (state_q == RUN && wb_valid) begin
         if (dmem_err) begin
            next_state = ERR;
            next_stat  = SADR;
         end else if (icode > IPOPQ) begin
            next_state = ERR;
            next_stat  = SINS;
         end else begin
            commit = 1'b1;
            if (icode == IHALT) begin
               next_state = HALT;
               next_stat  = SHLT;
            end
         end
      end
   end

   // dstM is written last so it wins when both ports target the same register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= (i == int'(SP_IDX)) ? SP_RESET : '0;
      end else if (commit) begin
         if (int'(dst_e) < NREG)
            rf[dst_e] <= valE;
         if (int'(dst_m) < NREG)
            rf[dst_m] <= valM;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   word_t cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (commit)
         cnt_q <= cnt_q + 64'd1;
   end

   assign retired_cnt = cnt_q;
`endif

   assign stat     = stat_q;
   assign wb_ready = (state_q == RUN);

   assign regmem0  = rf[0];
   assign regmem1  = rf[1];
   assign regmem2  = rf[2];
   assign regmem3  = rf[3];
   assign regmem4  = rf[4];
   assign regmem5  = rf[5];
   assign regmem6  = rf[6];
   assign regmem7  = rf[7];
   assign regmem8  = rf[8];
   assign regmem9  = rf[9];
   assign regmem10 = rf[10];
   assign regmem11 = rf[11];
   assign regmem12 = rf[12];
   assign regmem13 = rf[13];
   assign regmem14 = rf[14];

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vector table, hand-written corner sequences, then
// randomized instruction streams compared against an instruction-level reference model.
module tb_reg_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [3:0]  icode, rA, rB;
   logic        cnd;
   logic [63:0] valE, valM;
   logic        dmem_err;
   logic [63:0] regmem0, regmem1, regmem2, regmem3, regmem4, regmem5, regmem6, regmem7;
   logic [63:0] regmem8, regmem9, regmem10, regmem11, regmem12, regmem13, regmem14;
   logic [2:0]  stat;
   logic        wb_ready;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retired_cnt;
`endif

   always #5 clk = ~clk;

   reg_writeback dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
      .cnd(cnd), .valE(valE), .valM(valM), .dmem_err(dmem_err),
      .regmem0(regmem0), .regmem1(regmem1), .regmem2(regmem2), .regmem3(regmem3),
      .regmem4(regmem4), .regmem5(regmem5), .regmem6(regmem6), .regmem7(regmem7),
      .regmem8(regmem8), .regmem9(regmem9), .regmem10(regmem10), .regmem11(regmem11),
      .regmem12(regmem12), .regmem13(regmem13), .regmem14(regmem14),
      .stat(stat),
`ifdef WB_RETIRE_CNT_EN
      .retired_cnt(retired_cnt),
`endif
      .wb_ready(wb_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: architectural state only (registers, status code, retire count).
   logic [63:0] m_reg [15];
   int          m_stat;
   logic [63:0] m_cnt;

   function automatic logic [63:0] get_reg(int i);
      case (i)
         0: return regmem0;   1: return regmem1;   2: return regmem2;
         3: return regmem3;   4: return regmem4;   5: return regmem5;
         6: return regmem6;   7: return regmem7;   8: return regmem8;
         9: return regmem9;   10: return regmem10; 11: return regmem11;
         12: return regmem12; 13: return regmem13; 14: return regmem14;
         default: return 64'hx;
      endcase
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 15; i++) m_reg[i] = 64'h0;
      m_reg[14] = 64'h200;
      m_stat    = 1;
      m_cnt     = 64'h0;
   endtask

   // One retiring instruction, straight from the architectural rules.
   task automatic model_step(bit v, int ic, int a, int b, bit c,
                             logic [63:0] e, logic [63:0] m, bit er);
      int de, dm;
      if (m_stat != 1 || !v) return;
      if (er)      begin m_stat = 3; return; end
      if (ic > 11) begin m_stat = 4; return; end
      de = 15;
      dm = 15;
      if (ic == 2 && c)               de = b;
      if (ic == 3 || ic == 6)         de = b;
      if (ic >= 8 && ic <= 11)        de = 14;
      if (ic == 5 || ic == 11)        dm = a;
      if (de < 15) m_reg[de] = e;
      if (dm < 15) m_reg[dm] = m;
      m_cnt = m_cnt + 64'd1;
      if (ic == 0) m_stat = 2;
   endtask

   task automatic check_model(string tag);
      for (int i = 0; i < 15; i++)
         chk($sformatf("%s reg%0d", tag, i), get_reg(i), m_reg[i]);
      chk({tag, " stat"}, 64'(stat), 64'(m_stat));
      chk({tag, " wb_ready"}, 64'(wb_ready), 64'(m_stat == 1));
`ifdef WB_RETIRE_CNT_EN
      chk({tag, " retired_cnt"}, retired_cnt, m_cnt);
`endif
   endtask

   // Reset asserted mid-cycle; outputs checked asynchronously, before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      wb_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_model("reset");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge: present one cycle of inputs, then return at the next negedge.
   task automatic apply(bit v, logic [3:0] ic, logic [3:0] a, logic [3:0] b, bit c,
                        logic [63:0] e, logic [63:0] m, bit er);
      wb_valid = v; icode = ic; rA = a; rB = b; cnd = c;
      valE = e; valM = m; dmem_err = er;
      @(posedge clk);
      model_step(v, int'(ic), int'(a), int'(b), c, e, m, er);
      #1;
      wb_valid = 1'b0;
      dmem_err = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      bit          rst_first;
      bit          v;
      logic [3:0]  ic, a, b;
      bit          c;
      logic [63:0] e, m;
      bit          er;
      int          i1;
      logic [63:0] x1;
      int          i2;
      logic [63:0] x2;
      int          st;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int frozen;
      rst = 1'b1; wb_valid = 1'b0; icode = 4'd0; rA = 4'd0; rB = 4'd0; cnd = 1'b0;
      valE = 64'h0; valM = 64'h0; dmem_err = 1'b0;
      model_reset();

      //          rst v  ic     a      b      c  valE          valM          er  i1 exp1          i2 exp2         st
      tbl[0]  = '{1, 1, 4'd3,  4'hF,  4'd2,  0, 64'h1234,     64'h0,        0,  2, 64'h1234,     14, 64'h200,     1};
      tbl[1]  = '{0, 1, 4'd2,  4'hF,  4'd3,  0, 64'h99,       64'h0,        0,  3, 64'h0,        2,  64'h1234,    1};
      tbl[2]  = '{0, 1, 4'd2,  4'hF,  4'd3,  1, 64'h5,        64'h0,        0,  3, 64'h5,        2,  64'h1234,    1};
      tbl[3]  = '{0, 1, 4'd11, 4'd14, 4'hF,  0, 64'h208,      64'hABCD,     0, 14, 64'hABCD,     3,  64'h5,       1};
      tbl[4]  = '{0, 1, 4'd11, 4'd1,  4'hF,  0, 64'h210,      64'h7,        0,  1, 64'h7,        14, 64'h210,     1};
      tbl[5]  = '{0, 1, 4'd0,  4'hF,  4'hF,  0, 64'h0,        64'h0,        0, 14, 64'h210,      1,  64'h7,       2};
      tbl[6]  = '{0, 1, 4'd3,  4'hF,  4'd5,  0, 64'h9,        64'h0,        0,  5, 64'h0,        14, 64'h210,     2};
      tbl[7]  = '{1, 1, 4'd5,  4'd6,  4'd2,  0, 64'h40,       64'h55,       1,  6, 64'h0,        2,  64'h0,       3};
      tbl[8]  = '{1, 1, 4'd12, 4'd1,  4'd2,  0, 64'h1,        64'h2,        0, 14, 64'h200,      2,  64'h0,       4};
      tbl[9]  = '{1, 0, 4'd3,  4'hF,  4'd7,  0, 64'h77,       64'h0,        0,  7, 64'h0,        14, 64'h200,     1};
      tbl[10] = '{0, 1, 4'd10, 4'd3,  4'hF,  0, 64'h1F8,      64'h0,        0, 14, 64'h1F8,      3,  64'h0,       1};
      tbl[11] = '{0, 1, 4'd6,  4'd1,  4'd9,  0, 64'hAA,       64'h0,        0,  9, 64'hAA,       14, 64'h1F8,     1};
      tbl[12] = '{0, 1, 4'd3,  4'hF,  4'hF,  0, 64'h1,        64'h0,        0, 14, 64'h1F8,      9,  64'hAA,      1};

      for (int k = 0; k < 13; k++) begin
         if (tbl[k].rst_first) do_reset();
         apply(tbl[k].v, tbl[k].ic, tbl[k].a, tbl[k].b, tbl[k].c, tbl[k].e, tbl[k].m, tbl[k].er);
         chk($sformatf("vec%0d reg%0d", k, tbl[k].i1), get_reg(tbl[k].i1), tbl[k].x1);
         chk($sformatf("vec%0d reg%0d", k, tbl[k].i2), get_reg(tbl[k].i2), tbl[k].x2);
         chk($sformatf("vec%0d stat", k), 64'(stat), 64'(tbl[k].st));
         chk($sformatf("vec%0d wb_ready", k), 64'(wb_ready), 64'(tbl[k].st == 1));
      end

      // Reset raised while a write is being presented: the write must be discarded.
      do_reset();
      wb_valid = 1'b1; icode = 4'd3; rB = 4'd4; valE = 64'h44; dmem_err = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      chk("midwrite reg4", regmem4, 64'h0);
      chk("midwrite stat", 64'(stat), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      apply(1'b0, 4'd3, 4'hF, 4'd4, 1'b0, 64'h44, 64'h0, 1'b0);
      check_model("after midwrite");

`ifdef WB_RETIRE_CNT_EN
      do_reset();
      for (int k = 0; k < 3; k++) apply(1'b1, 4'd3, 4'hF, 4'(k), 1'b0, 64'(k + 1), 64'h0, 1'b0);
      apply(1'b0, 4'd3, 4'hF, 4'd8, 1'b0, 64'h8, 64'h0, 1'b0);
      apply(1'b0, 4'd3, 4'hF, 4'd8, 1'b0, 64'h8, 64'h0, 1'b0);
      apply(1'b1, 4'd0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
      chk("cnt after halt", retired_cnt, 64'd4);
      apply(1'b1, 4'd3, 4'hF, 4'd8, 1'b0, 64'h8, 64'h0, 1'b0);
      chk("cnt frozen", retired_cnt, 64'd4);
`endif

      // Randomized instruction streams with occasional halts, faults and bubbles.
      do_reset();
      frozen = 0;
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [3:0] ic;
         r = $urandom_range(0, 99);
         if (r < 2)      ic = 4'd0;
         else if (r < 4) ic = 4'(12 + $urandom_range(0, 3));
         else            ic = 4'($urandom_range(1, 11));
         apply($urandom_range(0, 3) != 0, ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 99) < 3);
         check_model($sformatf("rand%0d", n));
         if (m_stat != 1) begin
            frozen++;
            if (frozen > 3) begin
               do_reset();
               frozen = 0;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
